seq_functional_unit: RTL and testbench

Parametrised, registered successor of the datapath's combinational 16-bit functional unit.
- Same 4-bit opcode map, generalised to WIDTH bits.
- Multiply is an iterative shift-add over the low WIDTH/2 bits of each operand, taking WIDTH/2 cycles.
- Valid/ready handshakes on operand and result sides; result and CVZN flags are registered.
- Flags are correct per operation class: C/V only from add/subtract, 0 otherwise.

---
 rtl/fu_pkg.sv | 40 ++++
 rtl/fu_seq_multiplier.sv | 59 +++++
 rtl/seq_functional_unit.sv | 126 ++++++++++++
 tb/tb_seq_functional_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared opcode map, status bit positions and FSM encoding for the
// sequential functional unit.
package fu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_SAL = 4'b1110;
  localparam logic [3:0] OP_SAR = 4'b1111;

  localparam int unsigned ST_N = 0;
  localparam int unsigned ST_Z = 1;
  localparam int unsigned ST_C = 2;
  localparam int unsigned ST_V = 3;

  typedef logic [1:0] fu_state_t;
  localparam fu_state_t IDLE = 2'd0;
  localparam fu_state_t MUL  = 2'd1;
  localparam fu_state_t DONE = 2'd2;

  // Opcode classes: 01x? is add/sub, 10xx is multiply.
  function automatic logic is_arith_op(input logic [3:0] op);
    return op[3:2] == OP_ADD[3:2];
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return op[3:2] == OP_MUL[3:2];
  endfunction

  function automatic logic is_sub_op(input logic [3:0] op);
    return op[0] == OP_SUB[0];
  endfunction

endpackage

// File: rtl/fu_seq_multiplier.sv
// Iterative shift-add multiplier over two WIDTH/2-bit operands, one
// multiplier bit per cycle, producing a WIDTH-bit product.
module fu_seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic [WIDTH/2-1:0] i_mcand,
  input  logic [WIDTH/2-1:0] i_mplier,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_product
);
  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned IW   = $clog2(HALF);
  localparam int unsigned CW   = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [HALF-1:0]  r_mcand;
  logic [HALF-1:0]  r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [IW-1:0]    w_idx;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_acc_next;

  assign w_idx      = r_cnt[IW-1:0];
  assign w_addend   = {{HALF{1'b0}}, r_mcand} << w_idx;
  assign w_acc_next = r_mplier[w_idx] ? r_acc + w_addend : r_acc;

  // The final iteration is presented combinationally so the owner can
  // capture the product on the same edge that performs the last add.
  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_product = w_acc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_functional_unit.sv
// Registered functional unit: single-cycle logic/arith/shift ops and an
// iterative multiply, with valid/ready handshakes and CVZN status.
module seq_functional_unit
  import fu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);
  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned HALF = WIDTH / 2;

  fu_state_t        r_state;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_status;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_product;
  logic             w_sub;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_sum;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_alu;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_alu_status;
  logic [3:0]       w_mul_status;

  assign in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid   = (r_state == DONE);
  assign result      = r_result;
  assign status      = r_status;
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = is_mul_op(opcode);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_sh        = b[SHW-1:0];

  fu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_start   (w_mul_start),
    .i_mcand   (a[HALF-1:0]),
    .i_mplier  (b[HALF-1:0]),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_comb begin
    w_alu = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_sub = is_sub_op(opcode);
    w_bop = w_sub ? ~b : b;
    w_sum = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub};
    case (opcode)
      OP_AND:         w_alu = a & b;
      OP_OR:          w_alu = a | b;
      OP_NOT:         w_alu = ~a;
      OP_XOR:         w_alu = a ^ b;
      OP_SHL, OP_SAL: w_alu = a << w_sh;
      OP_SHR:         w_alu = a >> w_sh;
      OP_SAR:         w_alu = $signed(a) >>> w_sh;
      default: begin
        if (is_arith_op(opcode)) begin
          w_alu = w_sum[WIDTH-1:0];
          w_c   = w_sum[WIDTH];
          // carry into the MSB recovered from the sum bit and its operands
          w_v   = w_sum[WIDTH] ^ (w_sum[WIDTH-1] ^ a[WIDTH-1] ^ w_bop[WIDTH-1]);
        end
      end
    endcase
    w_alu_status       = '0;
    w_alu_status[ST_N] = w_alu[WIDTH-1];
    w_alu_status[ST_Z] = (w_alu == '0);
    w_alu_status[ST_C] = w_c;
    w_alu_status[ST_V] = w_v;
    w_mul_status       = '0;
    w_mul_status[ST_N] = w_product[WIDTH-1];
    w_mul_status[ST_Z] = (w_product == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // IDLE and DONE share issue logic; in DONE an accept implies out_ready.
          if (w_accept) begin
            r_state <= w_is_mul ? MUL : DONE;
            if (!w_is_mul) begin
              r_result <= w_alu;
              r_status <= w_alu_status;
            end
          end else if (out_ready) begin
            r_state <= IDLE;
          end
        end
        MUL: begin
          if (w_mul_done) begin
            r_state  <= DONE;
            r_result <= w_product;
            r_status <= w_mul_status;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_functional_unit.sv
// Self-checking bench for seq_functional_unit at WIDTH=16: directed cases
// plus randomized ops against an arithmetic reference model.
module tb_seq_functional_unit;
  localparam int unsigned W = 16;
  localparam int unsigned H = W / 2;

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic [3:0]   opcode    = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [3:0]   status;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_functional_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .status    (status)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the opcode rules.
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [3:0] st);
    longint ax, bx, full, sa;
    int     sh;
    logic   c, v;
    ax = longint'(x);
    bx = longint'(y);
    sh = int'(y) % 16;
    c  = 1'b0;
    v  = 1'b0;
    full = 0;
    if (op == 4'b0000)      full = ax & bx;
    else if (op == 4'b0001) full = ax | bx;
    else if (op == 4'b0010) full = 65535 - ax;
    else if (op == 4'b0011) full = ax ^ bx;
    else if (op[3:2] == 2'b01 && op[0] == 1'b0) full = ax + bx;
    else if (op[3:2] == 2'b01) full = ax - bx;
    else if (op[3:2] == 2'b10) full = (ax % 256) * (bx % 256);
    else if (op == 4'b1100 || op == 4'b1110) full = ax * (longint'(1) << sh);
    else if (op == 4'b1101) full = ax / (longint'(1) << sh);
    else begin
      sa   = x[W-1] ? ax - 65536 : ax;
      full = sa >>> sh;
    end
    r = 16'(full);
    if (op[3:2] == 2'b01 && op[0] == 1'b0) begin
      c = (full > 65535);
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else if (op[3:2] == 2'b01) begin
      c = (ax >= bx);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    st = {v, c, (r == '0), r[W-1]};
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int stall,
                       output logic [W-1:0] r, output logic [3:0] st);
    logic [W-1:0] er;
    logic [3:0]   es;
    int           lat, rdy_hi, k, exp_lat;
    model(op, x, y, er, es);
    exp_lat   = (op[3:2] == 2'b10) ? int'(H) + 1 : 1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    opcode    = op;
    a         = x;
    b         = y;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    opcode   = 4'($urandom);
    if (stall > 0) out_ready = 1'b0;
    lat    = 1;
    rdy_hi = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_hi++;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(rdy_hi), 32'd0);
    r  = result;
    st = status;
    chk({tag, "_res"}, 32'(r), 32'(er));
    chk({tag, "_st"}, 32'(st), 32'(es));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold"}, {15'd0, out_valid, result}, {15'd0, 1'b1, er});
    end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    logic [W-1:0] r;
    logic [3:0]   st;
    logic [3:0]   op;
    logic [W-1:0] x, y;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_st", 32'(status), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    do_op("add_ovf", 4'b0100, 16'h7FFF, 16'h0001, 0, r, st);
    chk("add_ovf_c", {28'd0, st, r}, {28'd0, 4'b1001, 16'h8000});
    do_op("sub_eq", 4'b0111, 16'h0005, 16'h0005, 0, r, st);
    chk("sub_eq_c", {28'd0, st, r}, {28'd0, 4'b0110, 16'h0000});
    do_op("sub_brw", 4'b0111, 16'h0000, 16'h0001, 1, r, st);
    chk("sub_brw_c", {28'd0, st, r}, {28'd0, 4'b0001, 16'hFFFF});
    do_op("mul_a", 4'b1000, 16'h12FF, 16'h3402, 0, r, st);
    chk("mul_a_c", {28'd0, st, r}, {28'd0, 4'b0000, 16'h01FE});
    do_op("mul_ff", 4'b1011, 16'h00FF, 16'h00FF, 2, r, st);
    chk("mul_ff_c", {28'd0, st, r}, {28'd0, 4'b0001, 16'hFE01});
    do_op("sar", 4'b1111, 16'h8000, 16'hFFF4, 0, r, st);
    chk("sar_c", {28'd0, st, r}, {28'd0, 4'b0001, 16'hF800});
    do_op("shr", 4'b1101, 16'h8000, 16'hFFF4, 0, r, st);
    chk("shr_c", {28'd0, st, r}, {28'd0, 4'b0000, 16'h0800});

    // Backpressure, then back-to-back issue from DONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode    = 4'b0000;
    a         = 16'h0F0F;
    b         = 16'h00FF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res", 32'(result), 32'h000F);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b1;
    opcode    = 4'b0011;
    a         = 16'h1234;
    b         = 16'h00FF;
    out_ready = 1'b1;
    #1;
    chk("b2b_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_res", 32'(result), 32'h12CB);
    tick();

    // Reset in the middle of a multiply.
    in_valid = 1'b1;
    opcode   = 4'b1000;
    a        = 16'h00AB;
    b        = 16'h00CD;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("rmul_valid", 32'(out_valid), 32'd0);
    chk("rmul_res", 32'(result), 32'd0);
    chk("rmul_st", 32'(status), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rmul_rdy", 32'(in_ready), 32'd1);
    do_op("post_rst", 4'b0100, 16'h0001, 16'h0001, 0, r, st);
    chk("post_rst_c", 32'(r), 32'h0002);

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom);
      x  = 16'($urandom);
      y  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x = (i % 2 == 1) ? 16'h8000 : 16'hFFFF;
      if ($urandom_range(0, 3) == 0) y = (i % 3 == 0) ? 16'h7FFF : 16'h0000;
      do_op("rnd", op, x, y, int'($urandom_range(0, 2)), r, st);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
